// File: rtl/mpm_pkg.sv
// mpm_pkg
// Shared types and parameter checks for the XOR-based multi-port memory
// initiator adapter (mpm_port_client) and its response FIFO.
//   mpm_req_t      : one request beat {we, addr, wdata, tag} at default widths
//   mpm_rsp_t      : one read response {data, tag} at default widths
//   mpm_params_ok  : elaboration-time sanity check of the adapter parameters
package mpm_pkg;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_DEPTH          = 512;
    localparam int DEF_AW             = $clog2(DEF_DEPTH);
    localparam int DEF_TAG_W          = 4;
    localparam int DEF_READ_LATENCY   = 2;
    localparam int DEF_HAZARD_WINDOW  = 3;
    localparam int DEF_RESP_DEPTH     = 4;

    typedef struct packed {
        logic                  we;
        logic [DEF_AW-1:0]     addr;
        logic [DEF_WIDTH-1:0]  wdata;
        logic [DEF_TAG_W-1:0]  tag;
    } mpm_req_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]  data;
        logic [DEF_TAG_W-1:0]  tag;
    } mpm_rsp_t;

    // The response FIFO must hold every read that can be in the memory
    // pipeline at once, otherwise the credit scheme could overflow it.
    // A hazard window of at least 2 is needed for the history to exist.
    function automatic bit mpm_params_ok(input int resp_depth,
                                         input int read_latency,
                                         input int hazard_window);
        return (resp_depth >= read_latency) && (read_latency >= 1) &&
               (hazard_window >= 2);
    endfunction

    localparam bit DEF_PARAMS_OK =
        mpm_params_ok(DEF_RESP_DEPTH, DEF_READ_LATENCY, DEF_HAZARD_WINDOW);

endpackage

// File: rtl/mpm_resp_fifo.sv
// mpm_resp_fifo
// Synchronous FIFO holding landed read responses. The head entry is kept in
// its own register so the output never depends combinationally on the
// storage array read.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle
//   push_data   : entry to enqueue
//   pop         : dequeue the head this cycle (ignored when empty)
//   head        : current head entry (valid when count != 0)
//   count       : number of stored entries
module mpm_resp_fifo
    import mpm_pkg::*;
#(
    parameter int DATA_W = DEF_WIDTH + DEF_TAG_W,
    parameter int DEPTH  = DEF_RESP_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] store [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // Pointers wrap explicitly so a non-power-of-two depth works.
    always_comb begin
        wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head register: after a pop the next entry comes from storage if one is
    // there, otherwise straight from a simultaneous push. A push into an
    // empty FIFO goes directly to the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
        end else if (do_pop) begin
            if (count > CW'(1)) begin
                head <= store[rd_ptr_nxt];
            end else if (do_push) begin
                head <= push_data;
            end
        end else if (do_push && (count == '0)) begin
            head <= push_data;
        end
    end

endmodule

// File: rtl/mpm_port_client.sv
// mpm_port_client
// Single-port initiator adapter for the XOR-based pipelined multi-port memory.
// Accepts read/write requests, drives one memory port, tracks reads through
// the fixed read latency and returns tagged data on a back-pressurable stream.
// Reads to an address still inside a recent write's pipeline are stalled.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   req_valid/req_ready               : request handshake
//   req_we/req_addr/req_wdata/req_tag : request payload (1 = write)
//   rsp_valid/rsp_ready               : response handshake
//   rsp_data/rsp_tag                  : read data and originating tag
//   mem_addr/mem_d/mem_en             : memory port address, data, write enable
//   mem_q                             : memory port read data
module mpm_port_client
    import mpm_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 512,
    parameter int TAG_W         = 4,
    parameter int READ_LATENCY  = 2,
    parameter int HAZARD_WINDOW = 3,
    parameter int RESP_DEPTH    = 4,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_d,
    output logic             mem_en,
    input  logic [WIDTH-1:0] mem_q
);

    // A write issued HAZARD_WINDOW cycles ago is already visible to a read,
    // so only the HAZARD_WINDOW-1 most recent writes need to be remembered.
    localparam int HIST = HAZARD_WINDOW - 1;
    localparam int CW   = $clog2(RESP_DEPTH + 1);
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(RESP_DEPTH);

    if (!mpm_params_ok(RESP_DEPTH, READ_LATENCY, HAZARD_WINDOW)) begin : g_param_error
        $error("mpm_port_client: RESP_DEPTH must be >= READ_LATENCY >= 1 and HAZARD_WINDOW >= 2");
    end

    logic [HIST-1:0]         hist_valid;
    logic [AW-1:0]           hist_addr [HIST];
    logic [READ_LATENCY-1:0] trk_valid;
    logic [TAG_W-1:0]        trk_tag [READ_LATENCY];
    logic [CW-1:0]           inflight_count;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_used;
    logic [AW-1:0]           addr_q;
    logic [WIDTH-1:0]        d_q;
    logic                    hazard;
    logic                    credit_full;
    logic                    accept;
    logic                    wr_issue;
    logic                    rd_issue;
    logic                    land;
    logic                    pop;
    logic [WIDTH+TAG_W-1:0]  fifo_head;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            if (hist_valid[i] && (hist_addr[i] == req_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Every read either in the memory pipeline or waiting in the FIFO holds a
    // credit; pops only show up in fifo_count on the following cycle.
    assign credit_used = {1'b0, inflight_count} + {1'b0, fifo_count};
    assign credit_full = (credit_used >= CREDIT_LIMIT);

    // Writes never stall: same-address write ordering is handled by the memory.
    assign req_ready = !(!req_we && (hazard || credit_full));
    assign accept    = req_valid && req_ready;
    assign wr_issue  = accept && req_we;
    assign rd_issue  = accept && !req_we;

    assign mem_en    = wr_issue;
    assign mem_addr  = accept ? req_addr  : addr_q;
    assign mem_d     = accept ? req_wdata : d_q;

    assign land      = trk_valid[READ_LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_head[WIDTH+TAG_W-1:TAG_W];
    assign rsp_tag   = fifo_head[TAG_W-1:0];

    // Port holds the last issued address/data while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            d_q    <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            d_q    <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid <= '0;
            for (int i = 0; i < HIST; i++) begin
                hist_addr[i] <= '0;
            end
        end else begin
            hist_valid[0] <= wr_issue;
            hist_addr[0]  <= req_addr;
            for (int i = 1; i < HIST; i++) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_addr[i]  <= hist_addr[i-1];
            end
        end
    end

    // Read tracker mirrors the memory read pipeline; the last stage lines up
    // with mem_q of the read it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                trk_tag[i] <= '0;
            end
        end else begin
            trk_valid[0] <= rd_issue;
            trk_tag[0]   <= req_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_tag[i]   <= trk_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_count <= '0;
        end else begin
            case ({rd_issue, land})
                2'b10:   inflight_count <= inflight_count + CW'(1);
                2'b01:   inflight_count <= inflight_count - CW'(1);
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    mpm_resp_fifo #(
        .DATA_W (WIDTH + TAG_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (land),
        .push_data ({mem_q, trk_tag[READ_LATENCY-1]}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mpm_port_client.sv
// tb_mpm_port_client
// Self-checking bench for mpm_port_client. A behavioural memory with a
// write-commit delay sits on the memory port; a reference model keeps the
// architectural memory contents and the ordered list of expected responses.
module tb_mpm_port_client;
    import mpm_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int TAG_W = 4;
    localparam int RL    = 2;
    localparam int HW    = 3;
    localparam int RD    = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_d;
    logic             mem_en;
    logic [WIDTH-1:0] mem_q;

    int errors = 0;
    int checks = 0;

    mpm_port_client #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W),
        .READ_LATENCY(RL), .HAZARD_WINDOW(HW), .RESP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] init_val(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ ({23'b0, a} * 32'h9E37_79B1);
    endfunction

    // Memory environment: a write commits HW-1 edges after it is issued, so a
    // read presented fewer than HW cycles after the write sees stale data.
    bit [WIDTH-1:0] mem_arr     [DEPTH];
    bit             mem_written [DEPTH];
    bit [WIDTH-1:0] rd_pipe     [RL];
    bit             wp_v        [HW-1];
    bit [AW-1:0]    wp_a        [HW-1];
    bit [WIDTH-1:0] wp_d        [HW-1];

    always @(posedge clk) begin
        rd_pipe[0] <= mem_written[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (wp_v[HW-2]) begin
            mem_arr[wp_a[HW-2]]     <= wp_d[HW-2];
            mem_written[wp_a[HW-2]] <= 1'b1;
        end
        wp_v[0] <= mem_en;
        wp_a[0] <= mem_addr;
        wp_d[0] <= mem_d;
        for (int i = 1; i < HW - 1; i++) begin
            wp_v[i] <= wp_v[i-1];
            wp_a[i] <= wp_a[i-1];
            wp_d[i] <= wp_d[i-1];
        end
    end
    assign mem_q = rd_pipe[RL-1];

    // Reference model: architectural contents plus expected responses in order.
    bit [WIDTH-1:0] shadow       [DEPTH];
    bit             shadow_valid [DEPTH];
    mpm_rsp_t       exp_q [$];

    logic             s_ready;
    logic             s_accept;
    logic             s_rsp_valid;
    logic             s_fire;
    logic [WIDTH-1:0] s_rsp_data;
    logic [TAG_W-1:0] s_rsp_tag;

    function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
        return shadow_valid[a] ? shadow[a] : init_val(a);
    endfunction

    task automatic set_idle();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic set_read(input logic [AW-1:0] a, input logic [TAG_W-1:0] t);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_tag = t;
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    endtask

    // One clock: sample on the falling edge, update the model, score any
    // response handshake, then move inputs just after the rising edge.
    task automatic step();
        mpm_rsp_t e;
        @(negedge clk);
        s_ready     = req_ready;
        s_accept    = req_valid && req_ready;
        s_rsp_valid = rsp_valid;
        s_fire      = rsp_valid && rsp_ready;
        s_rsp_data  = rsp_data;
        s_rsp_tag   = rsp_tag;
        checks++;
        if (mem_en !== (req_valid && req_ready && req_we)) begin
            errors++;
            $display("[TB] FAIL mem_en: got %b expected %b", mem_en, req_valid && req_ready && req_we);
        end
        if (s_accept) begin
            if (req_we) begin
                shadow[req_addr]       = req_wdata;
                shadow_valid[req_addr] = 1'b1;
            end else begin
                e.data = model_read(req_addr);
                e.tag  = req_tag;
                exp_q.push_back(e);
            end
        end
        if (s_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp_unexpected: got data=%h tag=%0d expected no response", rsp_data, rsp_tag);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_data, rsp_tag} !== {e.data, e.tag}) begin
                    errors++;
                    $display("[TB] FAIL rsp: got data=%h tag=%0d expected data=%h tag=%0d",
                             rsp_data, rsp_tag, e.data, e.tag);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        set_idle();
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        req_addr = '0; req_wdata = '0; req_tag = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, mem_en} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got ready/valid/en=%b expected 100", {req_ready, rsp_valid, mem_en});
        end
        checks++;
        if (rsp_data !== '0 || rsp_tag !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got data=%h tag=%0d expected 0/0", rsp_data, rsp_tag);
        end
        checks++;
        if (mem_addr !== '0 || mem_d !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem: got addr=%0d d=%h expected 0/0", mem_addr, mem_d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hazard();
        int stalls = 0;
        bit got    = 1'b0;
        bit found  = 1'b0;
        rsp_ready = 1'b1;
        set_write(9'd5, 32'hDEADBEEF);
        step();
        set_read(9'd5, 4'd3);
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (s_accept) got = 1'b1;
            else stalls++;
        end
        set_idle();
        checks++;
        if (!got || stalls != HW - 1) begin
            errors++;
            $display("[TB] FAIL hazard_stalls: got %0d (accepted=%b) expected %0d", stalls, got, HW - 1);
        end
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (s_fire) begin
                found = 1'b1;
                checks++;
                if (s_rsp_data !== 32'hDEADBEEF || s_rsp_tag !== 4'd3) begin
                    errors++;
                    $display("[TB] FAIL hazard_rsp: got %h/%0d expected deadbeef/3", s_rsp_data, s_rsp_tag);
                end
            end
        end
        if (!found) begin
            errors++;
            $display("[TB] FAIL hazard_timeout: got no response expected one");
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        drain(6);
        for (int c = 0; c < 40; c++) begin
            if (c < 16) set_read(9'($urandom_range(16, 511)), 4'(c));
            else        set_idle();
            step();
            if (c < 16) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready: cycle %0d got %b expected 1", c, s_ready);
                end
            end
            if (s_fire) begin
                checks++;
                if (s_rsp_tag !== 4'(n) || c != RL + 1 + n) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp: got tag=%0d at cycle %0d expected tag=%0d at cycle %0d",
                             s_rsp_tag, c, n, RL + 1 + n);
                end
                n++;
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 16", n);
        end
    endtask

    task automatic test_credit();
        int acc = 0;
        int n   = 0;
        drain(6);
        rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            set_read(9'(100 + acc), 4'(acc));
            step();
            if (s_accept) acc++;
        end
        checks++;
        if (acc != RD || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL credit_accept: got %0d ready=%b expected %0d ready=0", acc, s_ready, RD);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && n < 8; c++) begin
            if (acc < 8) set_read(9'(100 + acc), 4'(acc));
            else         set_idle();
            step();
            if (s_accept) acc++;
            if (s_fire) begin
                checks++;
                if (s_rsp_tag !== 4'(n)) begin
                    errors++;
                    $display("[TB] FAIL credit_order: got tag=%0d expected %0d", s_rsp_tag, n);
                end
                n++;
            end
        end
        set_idle();
        checks++;
        if (n != 8 || acc != 8) begin
            errors++;
            $display("[TB] FAIL credit_drain: got %0d responses %0d accepts expected 8/8", n, acc);
        end
    endtask

    task automatic test_no_false_hazard();
        drain(6);
        set_write(9'd7, $urandom);
        step();
        set_read(9'd8, 4'd9);
        step();
        checks++;
        if (s_accept !== 1'b1) begin
            errors++;
            $display("[TB] FAIL neighbour_read: got accept=%b expected 1", s_accept);
        end
        drain(8);
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_read(9'(200 + i), 4'(i));
            step();
            checks++;
            if (s_accept !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midrst_issue: read %0d got accept=%b expected 1", i, s_accept);
            end
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_queued: got rsp_valid=%b expected 1", rsp_valid);
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (s_rsp_valid !== 1'b0 || s_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midrst_after: cycle %0d got valid=%b ready=%b expected 0/1",
                         c, s_rsp_valid, s_ready);
            end
        end
    endtask

    task automatic test_random();
        mpm_req_t p;
        bit pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                p.we    = 1'($urandom_range(0, 1));
                p.addr  = 9'($urandom_range(0, 15));
                p.wdata = $urandom;
                p.tag   = 4'($urandom_range(0, 15));
                pending = 1'b1;
            end
            if (pending) begin
                if (p.we) set_write(p.addr, p.wdata);
                else      set_read(p.addr, p.tag);
            end else begin
                set_idle();
            end
            rsp_ready = 1'($urandom_range(0, 1));
            step();
            if (s_accept) pending = 1'b0;
        end
        set_idle();
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_drain: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_hazard();
        test_back_to_back();
        test_credit();
        test_no_false_hazard();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
